// File: rtl/oled_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : oled_init_seq
// Purpose  : Power-up command sequencer for an SSD1306-class OLED. Issues the
//            25-byte init table as IIC_Driver write transactions. With
//            OLED_CLEAR_EN defined it also clears display RAM.
// Revision : 1.0 - initial release
// ============================================================================
module oled_init_seq #(
    parameter logic [7:0] SLAVE_ADDR = 8'h78,
    parameter int         PWRUP_DLY  = 100000,
    parameter int         GAP_CYC    = 2,
    parameter int         TIMEOUT    = 200000
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        restart,
    output logic [15:0] IICSlave,
    output logic        IICWriteReq,
    output logic [7:0]  IICWriteData,
    input  logic        IICWriteDone,
    output logic        init_busy,
    output logic        init_done,
    output logic        init_err,
    output logic [4:0]  cmd_idx
);

    localparam int c_PW_W  = (PWRUP_DLY > 1) ? $clog2(PWRUP_DLY) : 1;
    localparam int c_TO_W  = ($clog2(TIMEOUT) > 18) ? $clog2(TIMEOUT) : 18;
    localparam int c_GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [c_PW_W-1:0]  c_PW_LAST  = c_PW_W'(PWRUP_DLY - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYC - 1);

    localparam logic [4:0] c_LAST_IDX  = 5'd24;
    localparam logic [7:0] c_CTRL_CMD  = 8'h00;
    localparam logic [7:0] c_CTRL_DATA = 8'h40;

    localparam logic [2:0] c_S_PWRUP = 3'd0;
    localparam logic [2:0] c_S_LOAD  = 3'd1;
    localparam logic [2:0] c_S_REQ   = 3'd2;
    localparam logic [2:0] c_S_GAP   = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;
    localparam logic [2:0] c_S_ERR   = 3'd5;
    localparam logic [2:0] c_S_CLR   = 3'd6;

    function automatic logic [7:0] f_init_byte(input logic [4:0] idx);
        case (idx)
            5'd0:    f_init_byte = 8'hAE;
            5'd1:    f_init_byte = 8'hD5;
            5'd2:    f_init_byte = 8'h80;
            5'd3:    f_init_byte = 8'hA8;
            5'd4:    f_init_byte = 8'h3F;
            5'd5:    f_init_byte = 8'hD3;
            5'd6:    f_init_byte = 8'h00;
            5'd7:    f_init_byte = 8'h40;
            5'd8:    f_init_byte = 8'h8D;
            5'd9:    f_init_byte = 8'h14;
            5'd10:   f_init_byte = 8'h20;
            5'd11:   f_init_byte = 8'h00;
            5'd12:   f_init_byte = 8'hA1;
            5'd13:   f_init_byte = 8'hC8;
            5'd14:   f_init_byte = 8'hDA;
            5'd15:   f_init_byte = 8'h12;
            5'd16:   f_init_byte = 8'h81;
            5'd17:   f_init_byte = 8'hCF;
            5'd18:   f_init_byte = 8'hD9;
            5'd19:   f_init_byte = 8'hF1;
            5'd20:   f_init_byte = 8'hDB;
            5'd21:   f_init_byte = 8'h40;
            5'd22:   f_init_byte = 8'hA4;
            5'd23:   f_init_byte = 8'hA6;
            default: f_init_byte = 8'hAF;
        endcase
    endfunction

    logic [2:0]         r_state;
    logic [c_PW_W-1:0]  r_pw_cnt;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [4:0]         r_idx;
    logic [15:0]        r_slave;
    logic [7:0]         r_data;
    logic               r_req;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

`ifdef OLED_CLEAR_EN
    // Column range 0..127, page range 0..7: the whole 128x64 RAM.
    function automatic logic [7:0] f_clr_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    f_clr_byte = 8'h21;
            3'd1:    f_clr_byte = 8'h00;
            3'd2:    f_clr_byte = 8'h7F;
            3'd3:    f_clr_byte = 8'h22;
            3'd4:    f_clr_byte = 8'h00;
            default: f_clr_byte = 8'h07;
        endcase
    endfunction

    logic        r_in_clr;
    logic        r_clr_data;
    logic [2:0]  r_clr_cmd;
    logic [10:0] r_clr_cnt;
`endif

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_S_PWRUP;
            r_pw_cnt  <= '0;
            r_to_cnt  <= '0;
            r_gap_cnt <= '0;
            r_idx     <= 5'd0;
            r_slave   <= {SLAVE_ADDR, c_CTRL_CMD};
            r_data    <= 8'h00;
            r_req     <= 1'b0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef OLED_CLEAR_EN
            r_in_clr   <= 1'b0;
            r_clr_data <= 1'b0;
            r_clr_cmd  <= 3'd0;
            r_clr_cnt  <= 11'd0;
`endif
        end else begin
            case (r_state)
                c_S_PWRUP: begin
                    if (r_pw_cnt == c_PW_LAST) begin
                        r_state <= c_S_LOAD;
                        r_idx   <= 5'd0;
                        r_slave <= {SLAVE_ADDR, c_CTRL_CMD};
                        r_data  <= f_init_byte(5'd0);
                    end else begin
                        r_pw_cnt <= r_pw_cnt + c_PW_W'(1);
                    end
                end
                c_S_LOAD: begin
                    r_state  <= c_S_REQ;
                    r_req    <= 1'b1;
                    r_to_cnt <= '0;
                end
`ifdef OLED_CLEAR_EN
                c_S_CLR: begin
                    r_state  <= c_S_REQ;
                    r_req    <= 1'b1;
                    r_to_cnt <= '0;
                end
`endif
                c_S_REQ: begin
                    // A completion on the terminal-count cycle still counts.
                    if (IICWriteDone) begin
                        r_req     <= 1'b0;
                        r_gap_cnt <= '0;
                        r_state   <= c_S_GAP;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        r_req   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= c_S_ERR;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_W'(1);
                    end
                end
                c_S_GAP: begin
                    if (r_gap_cnt != c_GAP_LAST) begin
                        r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
                    end else
`ifdef OLED_CLEAR_EN
                    if (r_in_clr) begin
                        if (!r_clr_data) begin
                            if (r_clr_cmd == 3'd5) begin
                                r_clr_data <= 1'b1;
                                r_clr_cnt  <= 11'd0;
                                r_slave    <= {SLAVE_ADDR, c_CTRL_DATA};
                                r_data     <= 8'h00;
                            end else begin
                                r_clr_cmd <= r_clr_cmd + 3'd1;
                                r_data    <= f_clr_byte(r_clr_cmd + 3'd1);
                            end
                            r_state <= c_S_CLR;
                        end else if (r_clr_cnt == 11'd1023) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= c_S_DONE;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + 11'd1;
                            r_state   <= c_S_CLR;
                        end
                    end else
`endif
                    if (r_idx != c_LAST_IDX) begin
                        r_idx   <= r_idx + 5'd1;
                        r_slave <= {SLAVE_ADDR, c_CTRL_CMD};
                        r_data  <= f_init_byte(r_idx + 5'd1);
                        r_state <= c_S_LOAD;
                    end else begin
`ifdef OLED_CLEAR_EN
                        r_in_clr   <= 1'b1;
                        r_clr_data <= 1'b0;
                        r_clr_cmd  <= 3'd0;
                        r_slave    <= {SLAVE_ADDR, c_CTRL_CMD};
                        r_data     <= f_clr_byte(3'd0);
                        r_state    <= c_S_CLR;
`else
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_S_DONE;
`endif
                    end
                end
                c_S_DONE, c_S_ERR: begin
                    if (restart) begin
                        r_idx   <= 5'd0;
                        r_slave <= {SLAVE_ADDR, c_CTRL_CMD};
                        r_data  <= f_init_byte(5'd0);
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= c_S_LOAD;
`ifdef OLED_CLEAR_EN
                        r_in_clr <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= c_S_PWRUP;
                end
            endcase
        end
    end

    assign IICSlave     = r_slave;
    assign IICWriteReq  = r_req;
    assign IICWriteData = r_data;
    assign init_busy    = r_busy;
    assign init_done    = r_done;
    assign init_err     = r_err;
    assign cmd_idx      = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_oled_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_oled_init_seq
// Purpose  : Self-checking bench for oled_init_seq with a transaction-timeline
//            model and an IIC_Driver responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oled_init_seq;

    localparam int c_PWRUP = 40;
    localparam int c_GAP   = 2;
    localparam int c_TMO   = 64;
    localparam int c_RESP  = 10;
`ifdef OLED_CLEAR_EN
    localparam int c_NTX = 1055;
`else
    localparam int c_NTX = 25;
`endif
    localparam int c_BUDGET = c_PWRUP + c_NTX * (c_RESP + c_GAP + 2) + 500;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic        iic_done = 1'b0;
    logic [15:0] IICSlave;
    logic        IICWriteReq;
    logic [7:0]  IICWriteData;
    logic        init_busy;
    logic        init_done;
    logic        init_err;
    logic [4:0]  cmd_idx;

    oled_init_seq #(
        .SLAVE_ADDR (8'h78),
        .PWRUP_DLY  (c_PWRUP),
        .GAP_CYC    (c_GAP),
        .TIMEOUT    (c_TMO)
    ) dut (
        .sys_clk      (clk),
        .rst          (rst),
        .restart      (restart),
        .IICSlave     (IICSlave),
        .IICWriteReq  (IICWriteReq),
        .IICWriteData (IICWriteData),
        .IICWriteDone (iic_done),
        .init_busy    (init_busy),
        .init_done    (init_done),
        .init_err     (init_err),
        .cmd_idx      (cmd_idx)
    );

    initial forever #5 clk = ~clk;

    int vec  = 0;
    int miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected transaction list built straight from the command tables.
    logic [7:0]  c_tbl [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                                8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                                8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
    logic [7:0]  c_clr [6]  = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
    logic [7:0]  e_data  [c_NTX];
    logic [15:0] e_slave [c_NTX];

    // Timeline model: when requests rise/fall and when flags change.
    int cyc = 0, m_k = 0, m_rise_at = 0, m_finish_at = -1, m_since = 0;
    bit m_req = 0, m_done = 0, m_err = 0;

    initial forever begin
        bit term;
        @(posedge clk);
        if (rst) begin
            cyc = 0; m_req = 0; m_k = 0; m_rise_at = c_PWRUP + 1;
            m_finish_at = -1; m_done = 0; m_err = 0;
        end else begin
            cyc++;
            term = m_done || m_err;
            if (m_req) begin
                if (iic_done) begin
                    m_req = 0;
                    m_k++;
                    if (m_k == c_NTX) m_finish_at = cyc + c_GAP;
                    else m_rise_at = cyc + c_GAP + 1;
                end else if (cyc - m_since == c_TMO) begin
                    m_req = 0;
                    m_err = 1;
                end
            end else if (!term && cyc == m_rise_at) begin
                m_req = 1;
                m_since = cyc;
            end
            if (cyc == m_finish_at) m_done = 1;
            if (term && restart) begin
                m_done = 0; m_err = 0; m_k = 0;
                m_finish_at = -1; m_rise_at = cyc + 1;
            end
        end
    end

    // Compare process: every cycle out of reset.
    initial forever begin
        int e_idx;
        @(negedge clk);
        if (!rst) begin
            e_idx = (m_k > 24) ? 24 : m_k;
            chk("req", IICWriteReq, m_req);
            chk("busy", init_busy, !(m_done || m_err));
            chk("done", init_done, m_done);
            chk("err", init_err, m_err);
            if (m_req || (m_rise_at == cyc + 1 && !m_done && !m_err)) begin
                chk("slave", IICSlave, e_slave[m_k]);
                chk("data", IICWriteData, e_data[m_k]);
                chk("cmd_idx", cmd_idx, e_idx);
            end else if (m_done || m_err) begin
                chk("cmd_idx_term", cmd_idx, e_idx);
            end
        end
    end

    // Responder, stray-done / restart injector, and request capture.
    bit silent = 0, stray_pending = 0, midseq_pending = 0, req_restart = 0;
    int resp_cnt = 0, restart_cyc = 0;
    bit prev_req = 0;
    logic [7:0]  cap_data[$];
    logic [15:0] cap_slave[$];
    int          cap_cyc[$];

    initial forever begin
        @(negedge clk);
        iic_done = 1'b0;
        restart  = 1'b0;
        if (rst) begin
            resp_cnt = 0;
            prev_req = 0;
        end else begin
            if (req_restart) begin
                restart = 1'b1; req_restart = 0; restart_cyc = cyc;
            end else if (midseq_pending && IICWriteReq && cmd_idx == 5'd3) begin
                restart = 1'b1; midseq_pending = 0;
            end
            if (IICWriteReq) begin
                if (!prev_req) begin
                    cap_data.push_back(IICWriteData);
                    cap_slave.push_back(IICSlave);
                    cap_cyc.push_back(cyc);
                end
                resp_cnt++;
                if (resp_cnt == c_RESP && !(silent && cmd_idx == 5'd5)) iic_done = 1'b1;
            end else begin
                resp_cnt = 0;
                if (prev_req && stray_pending && cmd_idx == 5'd6) begin
                    iic_done = 1'b1; stray_pending = 0;
                end
            end
            prev_req = IICWriteReq;
        end
    end

    task automatic clear_cap();
        cap_data.delete(); cap_slave.delete(); cap_cyc.delete();
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!init_busy && n < 20) begin @(negedge clk); n++; end
        chk("became_busy", init_busy, 1'b1);
    endtask

    task automatic wait_term();
        int n = 0;
        while (!(init_done || init_err) && n < c_BUDGET) begin @(negedge clk); n++; end
        chk("terminated", init_done | init_err, 1'b1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < c_NTX; i++) begin
            if (i < 25) begin
                e_data[i] = c_tbl[i]; e_slave[i] = 16'h7800;
            end else if (i < 31) begin
                e_data[i] = c_clr[i-25]; e_slave[i] = 16'h7800;
            end else begin
                e_data[i] = 8'h00; e_slave[i] = 16'h7840;
            end
        end

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_req", IICWriteReq, 1'b0);
        chk("rst_slave", IICSlave, 16'h7800);
        chk("rst_data", IICWriteData, 8'h00);
        chk("rst_busy", init_busy, 1'b1);
        chk("rst_done", init_done, 1'b0);
        chk("rst_err", init_err, 1'b0);
        chk("rst_idx", cmd_idx, 5'd0);

        // Full run with a mid-sequence restart and a stray done in GAP
        clear_cap();
        midseq_pending = 1; stray_pending = 1;
        rst = 1'b0;
        wait_term();
        chk("t1_count", cap_data.size(), c_NTX);
        chk("t1_first_rise", cap_cyc[0], c_PWRUP + 1);
        chk("t1_rise_spacing", cap_cyc[1] - cap_cyc[0], c_RESP + c_GAP + 1);
        chk("t1_byte0", cap_data[0], 8'hAE);
        chk("t1_byte9", cap_data[9], 8'h14);
        chk("t1_byte24", cap_data[24], 8'hAF);
        chk("t1_slave24", cap_slave[24], 16'h7800);
`ifdef OLED_CLEAR_EN
        chk("t1_clr_first", cap_data[25], 8'h21);
        chk("t1_clr_last_slave", cap_slave[1054], 16'h7840);
        chk("t1_clr_last_data", cap_data[1054], 8'h00);
`endif
        chk("t1_done", init_done, 1'b1);
        chk("t1_idx", cmd_idx, 5'd24);
        chk("t1_midseq_seen", midseq_pending, 1'b0);
        chk("t1_stray_seen", stray_pending, 1'b0);

        // Timeout at entry 5, then restart
        silent = 1; clear_cap();
        req_restart = 1;
        wait_busy();
        wait_term();
        chk("t2_err", init_err, 1'b1);
        chk("t2_req", IICWriteReq, 1'b0);
        chk("t2_idx", cmd_idx, 5'd5);
        chk("t2_count", cap_data.size(), 6);
        chk("t2_req_width", cyc - cap_cyc[5], c_TMO);
        silent = 0; clear_cap();
        req_restart = 1;
        wait_busy();
        chk("t2_err_cleared", init_err, 1'b0);
        wait_term();
        chk("t2_restart_latency", cap_cyc[0] - restart_cyc, 2);
        chk("t2_restart_byte0", cap_data[0], 8'hAE);
        chk("t2_count_after", cap_data.size(), c_NTX);

        // Asynchronous reset while entry 12 is in flight
        req_restart = 1;
        wait_busy();
        n = 0;
        while (!(IICWriteReq && cmd_idx == 5'd12) && n < c_BUDGET) begin @(negedge clk); n++; end
        chk("t3_reached_12", cmd_idx, 5'd12);
        #2 rst = 1'b1;
        #1 chk("t3_async_req", IICWriteReq, 1'b0);
        chk("t3_async_idx", cmd_idx, 5'd0);
        repeat (2) @(negedge clk);
        clear_cap();
        rst = 1'b0;
        wait_term();
        chk("t3_count", cap_data.size(), c_NTX);
        chk("t3_first_rise", cap_cyc[0], c_PWRUP + 1);
        chk("t3_byte0", cap_data[0], 8'hAE);
        chk("t3_done", init_done, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/oled_init_seq.md
# oled_init_seq

Power-up command sequencer for the SSD1306-class OLED on the I2C bus. Sits directly upstream of `IIC_Driver`: after reset it waits out the panel power-up delay, then walks a fixed 25-byte init command table, issuing one `IIC_Driver` write transaction per byte. Optionally it then clears display RAM. It reports completion or a bus timeout to the display logic behind it.

## Interface
- `SLAVE_ADDR`, 8'h78: 8-bit write address of the panel (7-bit 0x3C << 1).
- `PWRUP_DLY`, 100000: cycles to wait after reset before the first transaction.
- `GAP_CYC`, 2: minimum idle cycles with `IICWriteReq` low between transactions.
- `TIMEOUT`, 200000: maximum cycles `IICWriteReq` may stay high without `IICWriteDone`.
- `sys_clk` input, 1 bit: system clock; all logic is on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `restart` input, 1 bit: one-cycle pulse; re-runs the sequence, skipping the power-up delay.
- `IICSlave` output, 16 bits: {SLAVE_ADDR, control byte}. Control byte is 8'h00 for commands and 8'h40 for data.
- `IICWriteReq` output, 1 bit: write request to `IIC_Driver`.
- `IICWriteData` output, 8 bits: command or data byte.
- `IICWriteDone` input, 1 bit: one-cycle completion pulse from `IIC_Driver`.
- `init_busy` output, 1 bit: high whenever the sequencer is not in DONE or ERR.
- `init_done` output, 1 bit: high in DONE.
- `init_err` output, 1 bit: high in ERR.
- `cmd_idx` output, 5 bits: index of the current or last table entry.

## Operation
- Command table, indices 0..24: AE, D5, 80, A8, 3F, D3, 00, 40, 8D, 14, 20, 00, A1, C8, DA, 12, 81, CF, D9, F1, DB, 40, A4, A6, AF. Entries 20 00 select horizontal addressing.
- States and transitions:
  - PWRUP: count PWRUP_DLY cycles, then go to LOAD.
  - LOAD: drive `IICSlave` and `IICWriteData` for the current entry, then go to REQ.
  - REQ: hold `IICWriteReq` high until `IICWriteDone`.
  - GAP: idle for GAP_CYC cycles. Then either advance to the next entry and go to LOAD, or leave the table: go to CLR if `OLED_CLEAR_EN` is defined, otherwise to DONE.
  - DONE: terminal success.
  - ERR: terminal failure.
- Timeout:
  - A 18-bit or wider counter runs only in REQ and clears on entry to REQ.
  - When the counter reaches TIMEOUT-1 without `IICWriteDone`, go to ERR and drop `IICWriteReq`.
  - If `IICWriteDone` arrives in the same cycle as the terminal count, done wins.
- `restart` is honoured only in DONE or ERR. It goes to LOAD with `cmd_idx` = 0 and clears `init_err`. It is ignored while busy.
- `IICWriteDone` seen outside REQ is ignored.
- `rst` at any point, including mid-transaction, returns to PWRUP immediately, with `IICWriteReq` low. `IIC_Driver` shares the same reset.

## Timing
- Reset values:
  - `IICWriteReq` = 0, `IICSlave` = {SLAVE_ADDR, 8'h00}, `IICWriteData` = 8'h00.
  - `init_busy` = 1, `init_done` = 0, `init_err` = 0, `cmd_idx` = 0.
  - State is PWRUP with the delay counter at 0.
- The first `IICWriteReq` rises at cycle PWRUP_DLY+1 after reset deassertion: PWRUP_DLY cycles, then 1 cycle of LOAD.
- `IICSlave` and `IICWriteData` are registered. They are stable from 1 cycle before `IICWriteReq` rises until it falls.
- `IICWriteReq` falls on the clock edge that samples `IICWriteDone` = 1.
- The next request rises exactly GAP_CYC+1 cycles after the previous one falls: GAP plus LOAD.
- `init_done` asserts on the edge after the final GAP completes and stays high until `restart` or `rst`.

## Configuration
- `OLED_CLEAR_EN` defined: after the table, state CLR runs in two steps.
  - It first issues 6 commands: 21 00 7F 22 00 07, with control byte 8'h00.
  - It then issues 1024 data writes of 8'h00 with control byte 8'h40. These are counted by an 11-bit counter.
  - Every write uses the same LOAD/REQ/GAP handshake and timeout. After the last write, go to DONE.
  - `cmd_idx` holds at 24 during CLR.
- `OLED_CLEAR_EN` undefined: no CLR logic is built. DONE follows entry 24 directly, and total transactions are 25.

## Test plan
- Reset, then a responder that pulses `IICWriteDone` 10 cycles after each req rise -> first req at cycle PWRUP_DLY+1. The 25 captured bytes match the table in order, all with `IICSlave` = 16'h7800. `init_done` = 1 after entry 24.
- Same as above, but check timing: req low on the done edge and next req exactly GAP_CYC+1 cycles later. `IICSlave` and `IICWriteData` do not change while req is high.
- With `OLED_CLEAR_EN` defined -> 25 + 6 + 1024 = 1055 transactions. The last 1024 have `IICSlave` = 16'h7840 and data 8'h00.
- Responder stops answering at entry 5 -> after TIMEOUT cycles, req = 0, `init_err` = 1, `cmd_idx` = 5. Then `restart` -> first req 2 cycles later with data 8'hAE and `init_err` = 0.
- Assert `rst` while req is high at entry 12 -> req = 0 asynchronously. After release, the sequence restarts from PWRUP at entry 0.
- `restart` pulsed mid-sequence, and a stray `IICWriteDone` in GAP -> both ignored, and the byte order is unchanged.
